// File: rtl/rti_pkg.sv
// Shared widths, FSM encoding and the saturating accumulate helper for the
// range-time-intensity accumulator.
package rti_pkg;

  localparam int unsigned ADDR_WIDTH   = 12;
  localparam int unsigned DATA_WIDTH   = 48;
  localparam int unsigned IN_WIDTH     = 32;
  localparam int unsigned BINS_WIDTH   = ADDR_WIDTH + 1;
  localparam int unsigned CHIRPS_WIDTH = 16;
  localparam int unsigned FRAME_WIDTH  = 16;
  localparam int unsigned SUM_WIDTH    = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DUMP  = 2'd2
  } rti_state_e;

  typedef struct packed {
    logic                  ovf;
    logic [DATA_WIDTH-1:0] sum;
  } sat_sum_t;

  // Unsigned base + magnitude, clamped to all-ones when the carry escapes.
  function automatic sat_sum_t sat_add(input logic [DATA_WIDTH-1:0] base,
                                       input logic [IN_WIDTH-1:0]   mag);
    logic [SUM_WIDTH-1:0] full;
    sat_sum_t             res;
    full    = {1'b0, base} + SUM_WIDTH'(mag);
    res.ovf = full[DATA_WIDTH];
    res.sum = res.ovf ? {DATA_WIDTH{1'b1}} : full[DATA_WIDTH-1:0];
    return res;
  endfunction

endpackage

// File: rtl/rti_rmw_pipe.sv
// One-stage read-modify-write pipe: read issued on accept, saturating add and
// BRAM write one cycle later, with forwarding for same-address back-to-back beats.
module rti_rmw_pipe
  import rti_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [IN_WIDTH-1:0]   in_data_i,
  input  logic                  in_first_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  ovf_o
);

  logic                  stg_vld_q;
  logic [ADDR_WIDTH-1:0] stg_addr_q;
  logic [IN_WIDTH-1:0]   stg_data_q;
  logic                  stg_first_q;
  logic                  fwd_vld_q;
  logic [ADDR_WIDTH-1:0] fwd_addr_q;
  logic [DATA_WIDTH-1:0] fwd_sum_q;
  logic [DATA_WIDTH-1:0] base;
  sat_sum_t              sat;

  assign rd_en_o   = in_valid_i;
  assign rd_addr_o = in_addr_i;

  // First chirp overwrites; a write to the same bin last cycle is not yet visible on doa.
  always_comb begin
    base = rd_data_i;
    if (stg_first_q) begin
      base = '0;
    end else if (fwd_vld_q && (fwd_addr_q == stg_addr_q)) begin
      base = fwd_sum_q;
    end
    sat = sat_add(base, stg_data_q);
  end

  assign wr_en_o   = stg_vld_q;
  assign wr_addr_o = stg_addr_q;
  assign wr_data_o = sat.sum;
  assign ovf_o     = stg_vld_q & sat.ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q   <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      stg_first_q <= 1'b0;
      fwd_vld_q   <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_sum_q   <= '0;
    end else begin
      stg_vld_q <= in_valid_i;
      if (in_valid_i) begin
        stg_addr_q  <= in_addr_i;
        stg_data_q  <= in_data_i;
        stg_first_q <= in_first_i;
      end
      fwd_vld_q  <= stg_vld_q;
      fwd_addr_q <= stg_addr_q;
      fwd_sum_q  <= sat.sum;
    end
  end

endmodule

// File: rtl/axis_rti_accumulator.sv
// RTI frame accumulator: sums per-chirp range bins into external BRAM, then
// streams the frame out on AXI-Stream and starts the next frame.
module axis_rti_accumulator
  import rti_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BINS_WIDTH-1:0]   cfg_bins,
  input  logic [CHIRPS_WIDTH-1:0] cfg_chirps,
  input  logic [IN_WIDTH-1:0]     s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    bram_ena,
  output logic [ADDR_WIDTH-1:0]   bram_addra,
  input  logic [DATA_WIDTH-1:0]   bram_doa,
  output logic                    bram_enb,
  output logic                    bram_web,
  output logic [ADDR_WIDTH-1:0]   bram_addrb,
  output logic [DATA_WIDTH-1:0]   bram_dib,
  output logic                    bram_wea,
  output logic                    err_framing,
  output logic                    err_overflow,
  output logic [FRAME_WIDTH-1:0]  frame_count
);

  rti_state_e              state_q;
  logic [BINS_WIDTH-1:0]   bins_q;
  logic [CHIRPS_WIDTH-1:0] chirps_q;
  logic [ADDR_WIDTH-1:0]   bin_cnt_q;
  logic [CHIRPS_WIDTH-1:0] chirp_cnt_q;
  logic                    tready_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rd_pending_q;
  logic                    m_tvalid_q;
  logic                    m_tlast_q;
  logic                    err_framing_q;
  logic                    err_overflow_q;
  logic [FRAME_WIDTH-1:0]  frame_count_q;

  logic                  accept;
  logic                  last_bin;
  logic                  last_chirp;
  logic                  dump_rd;
  logic                  dump_last_rd;
  logic                  out_hs;
  logic                  frame_done;
  logic                  cfg_load;
  logic                  pipe_rd_en;
  logic [ADDR_WIDTH-1:0] pipe_rd_addr;
  logic                  pipe_wr_en;
  logic                  pipe_ovf;

  assign accept       = s_axis_tvalid & tready_q;
  assign last_bin     = (BINS_WIDTH'(bin_cnt_q) == (bins_q - BINS_WIDTH'(1)));
  assign last_chirp   = (chirp_cnt_q == (chirps_q - CHIRPS_WIDTH'(1)));
  assign dump_rd      = (state_q == ST_DUMP) & rd_pending_q & (~m_tvalid_q | m_axis_tready);
  assign dump_last_rd = (BINS_WIDTH'(rd_addr_q) == (bins_q - BINS_WIDTH'(1)));
  assign out_hs       = m_tvalid_q & m_axis_tready;
  assign frame_done   = out_hs & m_tlast_q;

  // Config tracks the inputs only while no frame is in progress.
  assign cfg_load = ((state_q == ST_ACCUM) && (chirp_cnt_q == '0) && (bin_cnt_q == '0) && !accept)
                    || frame_done;

  rti_rmw_pipe u_rmw (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (accept),
    .in_addr_i  (bin_cnt_q),
    .in_data_i  (s_axis_tdata),
    .in_first_i (chirp_cnt_q == '0),
    .rd_en_o    (pipe_rd_en),
    .rd_addr_o  (pipe_rd_addr),
    .rd_data_i  (bram_doa),
    .wr_en_o    (pipe_wr_en),
    .wr_addr_o  (bram_addrb),
    .wr_data_o  (bram_dib),
    .ovf_o      (pipe_ovf)
  );

  assign bram_ena      = pipe_rd_en | dump_rd;
  assign bram_addra    = dump_rd ? rd_addr_q : pipe_rd_addr;
  assign bram_enb      = pipe_wr_en;
  assign bram_web      = pipe_wr_en;
  assign bram_wea      = 1'b0;
  assign s_axis_tready = tready_q;
  assign m_axis_tdata  = m_tvalid_q ? bram_doa : '0;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign err_framing   = err_framing_q;
  assign err_overflow  = err_overflow_q;
  assign frame_count   = frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_ACCUM;
      bins_q         <= '0;
      chirps_q       <= '0;
      bin_cnt_q      <= '0;
      chirp_cnt_q    <= '0;
      tready_q       <= 1'b0;
      rd_addr_q      <= '0;
      rd_pending_q   <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      if (cfg_load) begin
        bins_q   <= cfg_bins;
        chirps_q <= cfg_chirps;
      end
      if (pipe_ovf) begin
        err_overflow_q <= 1'b1;
      end
      case (state_q)
        ST_ACCUM: begin
          tready_q <= 1'b1;
          if (accept) begin
            if (s_axis_tlast != last_bin) begin
              err_framing_q <= 1'b1;
            end
            if (last_bin) begin
              bin_cnt_q <= '0;
              if (last_chirp) begin
                chirp_cnt_q <= '0;
                tready_q    <= 1'b0;
                state_q     <= ST_DRAIN;
              end else begin
                chirp_cnt_q <= chirp_cnt_q + CHIRPS_WIDTH'(1);
              end
            end else begin
              bin_cnt_q <= bin_cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        // The final write lands during this cycle, so the dump may read next cycle.
        ST_DRAIN: begin
          rd_addr_q    <= '0;
          rd_pending_q <= 1'b1;
          state_q      <= ST_DUMP;
        end
        ST_DUMP: begin
          if (dump_rd) begin
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= dump_last_rd;
            rd_addr_q  <= rd_addr_q + ADDR_WIDTH'(1);
            if (dump_last_rd) begin
              rd_pending_q <= 1'b0;
            end
          end else if (out_hs) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
          end
          if (frame_done) begin
            frame_count_q <= frame_count_q + FRAME_WIDTH'(1);
            tready_q      <= 1'b1;
            state_q       <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rti_accumulator.sv
// Randomised bench for axis_rti_accumulator with a behavioural BRAM and a
// per-bin frame-sum reference model.
module tb_axis_rti_accumulator;
  import rti_pkg::*;

  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [SUM_WIDTH-1:0] MAX_SUM = {1'b0, {DATA_WIDTH{1'b1}}};

  logic                    clk = 1'b0;
  logic                    rst;
  logic [BINS_WIDTH-1:0]   cfg_bins;
  logic [CHIRPS_WIDTH-1:0] cfg_chirps;
  logic [IN_WIDTH-1:0]     s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic                    bram_ena;
  logic [ADDR_WIDTH-1:0]   bram_addra;
  logic [DATA_WIDTH-1:0]   bram_doa;
  logic                    bram_enb;
  logic                    bram_web;
  logic [ADDR_WIDTH-1:0]   bram_addrb;
  logic [DATA_WIDTH-1:0]   bram_dib;
  logic                    bram_wea;
  logic                    err_framing;
  logic                    err_overflow;
  logic [FRAME_WIDTH-1:0]  frame_count;

  always #5 clk = ~clk;

  axis_rti_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_bins      (cfg_bins),
    .cfg_chirps    (cfg_chirps),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .bram_ena      (bram_ena),
    .bram_addra    (bram_addra),
    .bram_doa      (bram_doa),
    .bram_enb      (bram_enb),
    .bram_web      (bram_web),
    .bram_addrb    (bram_addrb),
    .bram_dib      (bram_dib),
    .bram_wea      (bram_wea),
    .err_framing   (err_framing),
    .err_overflow  (err_overflow),
    .frame_count   (frame_count)
  );

  // Dual-port BRAM, read-before-write; scrub fills it with garbage, poke preloads a word.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  scrub = 1'b0;
  logic                  poke_en = 1'b0;
  logic [ADDR_WIDTH-1:0] poke_addr = '0;
  logic [DATA_WIDTH-1:0] poke_data = '0;

  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= DATA_WIDTH'({$urandom, $urandom});
    end else begin
      if (bram_ena) bram_doa <= mem[bram_addra];
      if (bram_enb && bram_web) mem[bram_addrb] <= bram_dib;
      if (poke_en) mem[poke_addr] <= poke_data;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-bin frame sums, sticky flags, frame tally.
  logic [DATA_WIDTH-1:0] acc [MEM_DEPTH];
  int                    m_bins, m_chirps, m_beat, m_frames;
  bit                    m_ovf, m_frm;
  logic [IN_WIDTH-1:0]   stim [$];

  task automatic model_start(input int b, input int c);
    cfg_bins   = BINS_WIDTH'(b);
    cfg_chirps = CHIRPS_WIDTH'(c);
    m_bins     = b;
    m_chirps   = c;
    m_beat     = 0;
    @(posedge clk); #1;
  endtask

  task automatic model_accept(input logic [IN_WIDTH-1:0] x, input bit tl);
    int bin, ch;
    logic [SUM_WIDTH-1:0] s;
    bin = m_beat % m_bins;
    ch  = m_beat / m_bins;
    if (tl != (bin == m_bins - 1)) m_frm = 1'b1;
    s = (ch == 0) ? SUM_WIDTH'(x) : SUM_WIDTH'(acc[bin]) + SUM_WIDTH'(x);
    if (s > MAX_SUM) begin
      s = MAX_SUM;
      m_ovf = 1'b1;
    end
    acc[bin] = s[DATA_WIDTH-1:0];
    m_beat++;
  endtask

  task automatic send(input int n, input int bad_last, input bit gaps);
    int bin;
    bit tl, ok;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bin = m_beat % m_bins;
      tl  = (bin == m_bins - 1);
      if (m_beat == bad_last) tl = ~tl;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = stim.pop_front();
      s_axis_tlast  = tl;
      ok = 1'b0;
      for (int w = 0; w < 200; w++) begin
        @(negedge clk);
        if (s_axis_tready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check_eq("accept_timeout", 64'(ok), 64'(1));
        s_axis_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      model_accept(s_axis_tdata, tl);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic collect(input bit rnd);
    int n, cyc, first;
    n = 0; cyc = 0; first = -1;
    m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (n < m_bins && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (m_axis_tvalid && first < 0) first = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq($sformatf("data[%0d]", n), 64'(m_axis_tdata), 64'(acc[n]));
        check_eq($sformatf("tlast[%0d]", n), 64'(m_axis_tlast), 64'(n == m_bins - 1));
        n++;
      end
      @(posedge clk); #1;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check_eq("out_count", 64'(n), 64'(m_bins));
    check_eq("first_valid_lat", 64'(first), 64'(3));
    m_frames++;
    @(negedge clk);
    check_eq("tvalid_after", 64'(m_axis_tvalid), 64'(0));
    check_eq("frame_count", 64'(frame_count), 64'(m_frames & 16'hffff));
    check_eq("tready_accum", 64'(s_axis_tready), 64'(1));
    check_eq("err_overflow", 64'(err_overflow), 64'(m_ovf));
    check_eq("err_framing", 64'(err_framing), 64'(m_frm));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    check_eq("rst_tready", 64'(s_axis_tready), 64'(0));
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check_eq("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check_eq("rst_frames", 64'(frame_count), 64'(0));
    check_eq("rst_err_ovf", 64'(err_overflow), 64'(0));
    check_eq("rst_err_frm", 64'(err_framing), 64'(0));
    check_eq("rst_bram_en", 64'({bram_ena, bram_enb, bram_wea}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c;
    rst = 1'b1;
    cfg_bins = '0; cfg_chirps = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    m_frames = 0; m_ovf = 1'b0; m_frm = 1'b0;
    scrub = 1'b1;
    @(posedge clk); #1;
    scrub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp 1..4 over three chirps
    model_start(4, 3);
    repeat (3) for (int i = 1; i <= 4; i++) stim.push_back(IN_WIDTH'(i));
    send(12, -1, 1'b0);
    collect(1'b0);

    // Single bin, back-to-back beats
    model_start(1, 5);
    repeat (5) stim.push_back(IN_WIDTH'(7));
    send(5, -1, 1'b0);
    collect(1'b0);

    // Eight bins with random output back-pressure
    model_start(8, 2);
    repeat (16) stim.push_back($urandom);
    send(16, -1, 1'b1);
    collect(1'b1);

    // Random shapes
    repeat (3) begin
      b = $urandom_range(1, 16);
      c = $urandom_range(1, 4);
      model_start(b, c);
      repeat (b * c) stim.push_back($urandom);
      send(b * c, -1, 1'b1);
      collect(1'b1);
    end

    // Saturation: preload near-full words before the second chirp
    model_start(2, 2);
    repeat (4) stim.push_back({IN_WIDTH{1'b1}});
    send(2, -1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    for (int a = 0; a < 2; a++) begin
      poke_en   = 1'b1;
      poke_addr = ADDR_WIDTH'(a);
      poke_data = {{(DATA_WIDTH-1){1'b1}}, 1'b0};
      acc[a]    = poke_data;
      @(posedge clk); #1;
    end
    poke_en = 1'b0;
    send(2, -1, 1'b0);
    collect(1'b0);

    // Early tlast on the third beat
    model_start(4, 1);
    repeat (4) stim.push_back(IN_WIDTH'($urandom_range(0, 1000)));
    send(4, 2, 1'b0);
    collect(1'b1);

    // Reset mid-chirp, then a clean frame over stale BRAM
    model_start(4, 2);
    stim.push_back(IN_WIDTH'(100));
    stim.push_back(IN_WIDTH'(200));
    send(2, -1, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset_state();
    m_frames = 0; m_ovf = 1'b0; m_frm = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    model_start(4, 1);
    for (int i = 5; i <= 8; i++) stim.push_back(IN_WIDTH'(i));
    send(4, -1, 1'b0);
    collect(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
